// File: rtl/word_serializer_pkg.sv
// -----------------------------------------------------------------------------
// word_serializer_pkg
// Shared definitions for the word serializer slice: the frame FSM state type,
// the line levels driven in the idle/start/stop portions of a frame, and the
// parity helper.
//
// Build option: WORD_SERIALIZER_PARITY_EN adds the PARITY state to the enum.
// -----------------------------------------------------------------------------
package word_serializer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef WORD_SERIALIZER_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } ws_state_e;

    // Line level on dout for the framing portions of the serial stream
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    // Even parity bit: XOR of all payload bits. Payloads are at most 32 bits
    // wide, so callers zero-extend; the extra zeros do not change the XOR.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// -----------------------------------------------------------------------------
// piso_shift_reg
// Parallel-in, serial-out shift register. A load captures a whole word; each
// shift moves the word one place to the right so the next bit appears at lsb.
//
// Ports:
//   clk        rising-edge clock
//   areset     asynchronous active-high reset, clears the register
//   load       capture load_data (wins over shift)
//   shift      shift right by one, zero fill from the top
//   load_data  parallel word, WIDTH bits
//   lsb        current least-significant bit (next serial bit)
// -----------------------------------------------------------------------------
module piso_shift_reg
    import word_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             lsb
);

    logic [WIDTH-1:0] sr_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= load_data;
        end else if (shift) begin
            sr_q <= {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    assign lsb = sr_q[0];

endmodule

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
// Serializes a WIDTH-bit word onto a single line as a frame:
//   start bit (0), WIDTH data bits LSB first, [even parity bit], stop bit (1).
// A new word may be accepted in IDLE or in the STOP cycle; accepting in STOP
// chains frames back to back with no idle bit between them.
//
// Build option: WORD_SERIALIZER_PARITY_EN inserts a PARITY state between DATA
// and STOP carrying the even parity of the payload. Without it the parity
// state and its register do not exist.
//
// Ports:
//   clk        rising-edge clock
//   areset     asynchronous active-high reset, aborts any frame in progress
//   in_data    parallel word to serialize (WIDTH bits)
//   in_valid   in_data is valid
//   in_ready   a word can be accepted this cycle (IDLE or STOP)
//   dout       registered serial line
//   busy       a frame is in progress (state other than IDLE)
//   done       one-cycle pulse during the stop bit
// -----------------------------------------------------------------------------
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    ws_state_e        state;
    logic [CNT_W-1:0] bit_cnt;
    logic             dout_q;
    logic             done_q;
    logic             accept;
    logic             shift_en;
    logic             sr_lsb;

    assign in_ready = (state == IDLE) || (state == STOP);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign dout     = dout_q;
    assign done     = done_q;

    // bit_cnt counts data bits already placed on dout. The register shifts in
    // the same cycle a bit is moved to dout, so sr_lsb always holds the next
    // bit; no shift once the last bit is out.
    assign shift_en = (state == START) || ((state == DATA) && (bit_cnt != LAST_BIT));

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk       (clk),
        .areset    (areset),
        .load      (accept),
        .shift     (shift_en),
        .load_data (in_data),
        .lsb       (sr_lsb)
    );

`ifdef WORD_SERIALIZER_PARITY_EN
    // Parity is taken from the word at acceptance, so later in_data changes
    // cannot disturb it.
    logic par_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= even_parity(32'(in_data));
        end
    end
`endif

    // Frame FSM: state, bit counter and the registered line outputs
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            dout_q  <= LINE_IDLE;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE, STOP: begin
                    if (accept) begin
                        state   <= START;
                        bit_cnt <= '0;
                        dout_q  <= LINE_START;
                    end else begin
                        state  <= IDLE;
                        dout_q <= LINE_IDLE;
                    end
                end
                START: begin
                    state   <= DATA;
                    dout_q  <= sr_lsb;
                    bit_cnt <= bit_cnt + CNT_ONE;
                end
                DATA: begin
                    if (bit_cnt != LAST_BIT) begin
                        dout_q  <= sr_lsb;
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end else begin
`ifdef WORD_SERIALIZER_PARITY_EN
                        state  <= PARITY;
                        dout_q <= par_q;
`else
                        state  <= STOP;
                        dout_q <= LINE_STOP;
                        done_q <= 1'b1;
`endif
                    end
                end
`ifdef WORD_SERIALIZER_PARITY_EN
                PARITY: begin
                    state  <= STOP;
                    dout_q <= LINE_STOP;
                    done_q <= 1'b1;
                end
`endif
                default: begin
                    state  <= IDLE;
                    dout_q <= LINE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_serializer
// Scoreboard bench for word_serializer (WIDTH=8). Each accepted word pushes
// its expected per-cycle line values; a negedge monitor pops one entry per
// cycle and compares dout/done/busy/in_ready. A 4-stage downstream shift
// register is fed from dout and compared against the expected line delayed
// four cycles. Follows WORD_SERIALIZER_PARITY_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_word_serializer;

    localparam int WIDTH = 8;
`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int PAR_LEN = 1;
`else
    localparam int PAR_LEN = 0;
`endif
    localparam int FRAME_LEN = 2 + WIDTH + PAR_LEN;

    logic             clk;
    logic             areset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             dout;
    logic             busy;
    logic             done;

    word_serializer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .areset   (areset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dout     (dout),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic dout;
        logic done;
        logic busy;
        logic rdy;
    } exp_t;

    exp_t       sb[$];
    int         n_checks     = 0;
    int         n_fail       = 0;
    int         cyc          = 0;
    int         acc_cnt      = 0;
    int         last_acc_cyc = 0;
    logic       model_ready  = 1'b1;
    logic [3:0] hist         = 4'hF;
    logic [3:0] chain_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Downstream 4-stage shift register, idles high like the line
    always_ff @(posedge clk or posedge areset) begin
        if (areset) chain_q <= 4'hF;
        else        chain_q <= {chain_q[2:0], dout};
    end

    task automatic push_frame(input logic [WIDTH-1:0] w);
        sb.push_back('{dout: 1'b0, done: 1'b0, busy: 1'b1, rdy: 1'b0});
        for (int i = 0; i < WIDTH; i++)
            sb.push_back('{dout: w[i], done: 1'b0, busy: 1'b1, rdy: 1'b0});
        if (PAR_LEN == 1)
            sb.push_back('{dout: ^w, done: 1'b0, busy: 1'b1, rdy: 1'b0});
        sb.push_back('{dout: 1'b1, done: 1'b1, busy: 1'b1, rdy: 1'b1});
    endtask

    // Acceptance model: a word is taken on a rising edge when in_valid is high
    // and the cycle just ending was idle or a stop bit.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!areset && in_valid && model_ready) begin
                push_frame(in_data);
                acc_cnt++;
                last_acc_cyc = cyc;
            end
        end
    end

    // Per-cycle monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (areset) begin
                sb.delete();
                model_ready = 1'b1;
                hist        = 4'hF;
                check_eq("rst_dout", dout, 1);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_done", done, 0);
                check_eq("rst_ready", in_ready, 1);
            end else begin
                if (sb.size() == 0) e = '{dout: 1'b1, done: 1'b0, busy: 1'b0, rdy: 1'b1};
                else                e = sb.pop_front();
                check_eq("dout", dout, e.dout);
                check_eq("done", done, e.done);
                check_eq("busy", busy, e.busy);
                check_eq("in_ready", in_ready, e.rdy);
                check_eq("chain_dout", chain_q[3], hist[3]);
                model_ready = e.rdy;
                hist        = {hist[2:0], e.dout};
            end
        end
    end

    // Present a word at a negedge, wait for the edge that takes it, then leave
    // in_valid asserted or drop it at the following negedge.
    task automatic send(input logic [WIDTH-1:0] w, input bit keep_valid);
        int start_cnt;
        start_cnt = acc_cnt;
        in_data   = w;
        in_valid  = 1'b1;
        for (int i = 0; i < 4 * FRAME_LEN && acc_cnt == start_cnt; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("accepted", (acc_cnt != start_cnt), 1);
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4 * FRAME_LEN && sb.size() != 0; i++)
            @(negedge clk);
        check_eq("drained", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int           first_cyc;
        int           rel_cyc;
        int           start_cnt;
        logic [WIDTH-1:0] w;

        areset   = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        check_eq("por_dout", dout, 1);
        check_eq("por_busy", busy, 0);
        check_eq("por_done", done, 0);
        check_eq("por_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        #1 areset = 1'b0;
        repeat (2) @(negedge clk);

        // Single frames, including the parity-distinguishing pair
        send(8'hA5, 1'b0);
        wait_idle();
        send(8'h07, 1'b0);
        wait_idle();

        // Back-to-back: valid held, second word accepted in the stop cycle
        send(8'hA5, 1'b1);
        first_cyc = last_acc_cyc;
        send(8'h3C, 1'b0);
        check_eq("b2b_gap", last_acc_cyc - first_cyc, FRAME_LEN);
        wait_idle();

        // Data hold: in_data changes mid-frame must not reach the line
        send(8'h00, 1'b0);
        repeat (3) @(negedge clk);
        in_data = 8'hFF;
        wait_idle();
        in_data = '0;

        // A few random words
        for (int k = 0; k < 4; k++) begin
            w = WIDTH'($urandom_range(0, 255));
            send(w, 1'b0);
            wait_idle();
        end

        // Mid-frame reset, then accept on the first edge after release
        send(8'h5A, 1'b0);
        repeat (3) @(negedge clk);
        #2 areset = 1'b1;
        #1;
        check_eq("mid_rst_dout", dout, 1);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        in_data  = 8'h96;
        in_valid = 1'b1;
        #1 areset = 1'b0;
        rel_cyc   = cyc;
        start_cnt = acc_cnt;
        for (int i = 0; i < 4 && acc_cnt == start_cnt; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("post_rst_accept_cyc", last_acc_cyc, rel_cyc + 1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, payload bits per frame (legal 2..32).
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-003 SHALL have port areset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_data, input, WIDTH, parallel word to serialize.
REQ-005 SHALL have port in_valid, input, 1, in_data valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept a word this cycle.
REQ-007 SHALL have port dout, output, 1, serial line driving the downstream shift register's din.
REQ-008 SHALL have port busy, output, 1, frame in progress (any state but IDLE).
REQ-009 SHALL have port done, output, 1, one-cycle pulse coincident with the stop bit.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY (only when the parity feature is built in), STOP.
REQ-011 SHALL accept a word on any rising edge where in_valid && in_ready, capturing in_data into an internal shift register.
REQ-012 SHALL drive in_ready=1 in IDLE and STOP only, combinationally from state; all other states 0.
REQ-013 SHALL drive dout from a register: 1 in IDLE and STOP, 0 in START, data bit in DATA, parity bit in PARITY.
REQ-014 SHALL enter START on the acceptance edge, so the start bit (0) appears on dout in the cycle immediately after acceptance.
REQ-015 SHALL then emit WIDTH data bits LSB first, one per cycle, counted by a bit counter of width $clog2(WIDTH)+1 that clears on every acceptance.
REQ-016 SHALL hold STOP exactly one cycle, asserting done=1 during that cycle only.
REQ-017 SHALL, on acceptance in STOP, go directly to START with no idle cycle between frames (back-to-back), else go to IDLE.
REQ-018 SHALL ignore in_data and in_valid changes while in START, DATA or PARITY; the captured word is unaffected.
REQ-019 SHALL have frame length 2+WIDTH cycles without parity and 3+WIDTH with parity; sustained throughput one word per frame length.

Reset
REQ-020 SHALL, while areset=1, force state IDLE, dout=1, busy=0, done=0, bit counter 0, shift register 0, asynchronously and regardless of clk.
REQ-021 SHALL abort a frame in progress on mid-frame reset; the partially sent word is discarded and not resent.
REQ-022 SHALL accept a word on the first rising edge after areset deasserts if in_valid=1.

Configuration
REQ-023 SHALL provide macro WORD_SERIALIZER_PARITY_EN; when defined, state PARITY is inserted between DATA and STOP, emitting even parity (XOR of all WIDTH bits) for one cycle.
REQ-024 SHALL, when WORD_SERIALIZER_PARITY_EN is undefined, omit state PARITY and its logic entirely; DATA goes straight to STOP.

Structure
REQ-025 SHALL place the state enum type and the IDLE/START/STOP line-level constants in shared package word_serializer_pkg.
REQ-026 SHALL use one sub-module, piso_shift_reg (parallel load, right shift, LSB out), for the data path; FSM and counter stay in word_serializer.

Verification
REQ-027 SHALL check reset: areset=1 mid-DATA -> dout=1, busy=0, in_ready=1 before the next clk edge.
REQ-028 SHALL check single frame: WIDTH=8, in_data=0xA5 accepted -> dout over the next 10 cycles = 0,1,0,1,0,0,1,0,1,1; done=1 in the 10th cycle only.
REQ-029 SHALL check parity build: 0xA5 -> parity bit 0 in cycle 10, stop in cycle 11; 0x07 -> parity bit 1.
REQ-030 SHALL check back-to-back: in_valid held 1 with 0xA5 then 0x3C -> 0x3C start bit directly follows 0xA5 stop bit, 20 cycles total, no idle 1 between.
REQ-031 SHALL check data hold: in_data changed to 0xFF mid-frame of 0x00 -> all eight data bits on dout remain 0.
REQ-032 SHALL check downstream chain: dout fed to the 4-stage shift register -> its dout equals this block's dout delayed 4 cycles.
